// File: rtl/audio_sample_mixer_if.sv
// Voice/gain inputs and mixed-sample outputs of the audio sample mixer.
// The voice source drives the master side; the mixer sits on the slave side.
interface audio_sample_mixer_if #(
  parameter int unsigned NCH = 4
);
  logic                  lrck;
  logic [NCH*16-1:0]     ch_in;
  logic [NCH*8-1:0]      ch_gain;
  logic                  mute;
  logic signed [15:0]    mix_out;
  logic                  mix_valid;
  logic                  clip;
  logic                  busy;
  logic                  overrun;

  modport master (
    output lrck, ch_in, ch_gain, mute,
    input  mix_out, mix_valid, clip, busy, overrun
  );

  modport slave (
    input  lrck, ch_in, ch_gain, mute,
    output mix_out, mix_valid, clip, busy, overrun
  );
endinterface

// File: rtl/audio_sample_mixer.sv
// Time-multiplexed N-voice mixer: one shared multiplier, per-frame gain slew,
// 16-bit saturation, one registered output sample per codec LR-clock frame.
module audio_sample_mixer #(
  parameter int unsigned NCH = 4
) (
  input  logic                clock,
  input  logic                reset,
  audio_sample_mixer_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(NCH);
  localparam int unsigned ACC_W  = 24 + IDX_W;
  localparam int unsigned PROD_W = 25;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;

  state_t                   state;
  logic                     sync1, sync2, prev;
  logic signed [15:0]       snap [NCH];
  logic [7:0]               cur_gain [NCH];
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;

  logic                     frame_edge_c;
  logic signed [15:0]       snap_sel_c;
  logic [7:0]               gain_sel_c;
  logic [7:0]               gain_dest_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  shifted_c;
  logic                     sat_hi_c, sat_lo_c;

  assign frame_edge_c = sync2 & ~prev;
  assign snap_sel_c   = snap[idx];
  assign gain_sel_c   = cur_gain[idx];
  assign gain_dest_c  = bus.mute ? 8'd0 : bus.ch_gain[8*idx +: 8];

  // Gain is zero-extended to 9 bits so 255 stays positive; product fits in 24 bits.
  assign prod_c    = PROD_W'(snap_sel_c) * PROD_W'($signed({1'b0, gain_sel_c}));
  assign shifted_c = acc >>> 7;
  assign sat_hi_c  = shifted_c > SAT_MAX;
  assign sat_lo_c  = shifted_c < SAT_MIN;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      prev          <= 1'b0;
      idx           <= '0;
      acc           <= '0;
      bus.mix_out   <= '0;
      bus.mix_valid <= 1'b0;
      bus.clip      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        snap[i]     <= '0;
        cur_gain[i] <= '0;
      end
    end else begin
      sync1         <= bus.lrck;
      sync2         <= sync1;
      prev          <= sync2;
      bus.mix_valid <= 1'b0;

      // Frames arriving while a mix is in flight are dropped, not queued.
      if (frame_edge_c && state != IDLE) bus.overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_edge_c) begin
            for (int i = 0; i < NCH; i++) snap[i] <= bus.ch_in[16*i +: 16];
            acc      <= '0;
            idx      <= '0;
            bus.busy <= 1'b1;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod_c);
          // Slew uses this frame's gain first; the stepped value applies next frame.
          if (gain_sel_c < gain_dest_c)      cur_gain[idx] <= gain_sel_c + 8'd1;
          else if (gain_sel_c > gain_dest_c) cur_gain[idx] <= gain_sel_c - 8'd1;
          if (idx == IDX_LAST) state <= SAT;
          else                 idx   <= idx + IDX_W'(1);
        end
        SAT: begin
          if (sat_hi_c)      bus.mix_out <= 16'sh7fff;
          else if (sat_lo_c) bus.mix_out <= 16'sh8000;
          else               bus.mix_out <= shifted_c[15:0];
          bus.clip      <= sat_hi_c | sat_lo_c;
          bus.mix_valid <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_sample_mixer.sv
// Directed bench for audio_sample_mixer (NCH=4): fade-in, saturation, floor
// rounding and latency, mute slew, overrun and asynchronous mid-frame reset.
module tb_audio_sample_mixer;
  localparam int unsigned NCH = 4;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  int   f_out, f_clip, f_lat, f_width, f_busy;

  audio_sample_mixer_if #(.NCH(NCH)) bus ();

  audio_sample_mixer #(.NCH(NCH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One lrck pulse; waits for the resulting mix_valid and records result and timing.
  task automatic run_frame();
    int done;
    int busy_t;
    done   = 0;
    busy_t = -1;
    @(negedge clock) bus.lrck = 1'b1;
    for (int t = 0; t < 40 && done == 0; t++) begin
      @(negedge clock);
      if (t == 3) bus.lrck = 1'b0;
      if (bus.busy && busy_t < 0) busy_t = t;
      if (bus.mix_valid) begin
        f_out  = int'($signed(bus.mix_out));
        f_clip = int'(bus.clip);
        f_busy = int'(bus.busy);
        f_lat  = t - busy_t;
        done   = 1;
      end
    end
    bus.lrck = 1'b0;
    check("frame_done", done, 1);
    @(negedge clock) f_width = int'(bus.mix_valid);
    repeat (2) @(negedge clock);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mix_out"},   int'($signed(bus.mix_out)), 0);
    check({tag, "_mix_valid"}, int'(bus.mix_valid), 0);
    check({tag, "_clip"},      int'(bus.clip), 0);
    check({tag, "_busy"},      int'(bus.busy), 0);
    check({tag, "_overrun"},   int'(bus.overrun), 0);
  endtask

  initial begin
    int g;
    int valids;
    int seen;
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.lrck    = 1'b0;
    bus.mute    = 1'b0;
    bus.ch_in   = {16'sd0, 16'sd0, 16'sd0, 16'sd1000};
    bus.ch_gain = {8'd128, 8'd128, 8'd128, 8'd128};
    repeat (2) @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Fade-in from zero gain: frame n uses gain n-1.
    for (int n = 1; n <= 130; n++) begin
      run_frame();
      g = (n - 1 > 128) ? 128 : n - 1;
      check($sformatf("fade_out_%0d", n), f_out, (1000 * g) / 128);
      check($sformatf("fade_clip_%0d", n), f_clip, 0);
    end

    // Saturation both ways, then recovery.
    bus.ch_in = {16'sd0, 16'sd0, 16'sd32767, 16'sd32767};
    run_frame();
    check("sat_pos_out", f_out, 32767);
    check("sat_pos_clip", f_clip, 1);
    bus.ch_in = {16'sd0, 16'sd0, -16'sd32768, -16'sd32768};
    run_frame();
    check("sat_neg_out", f_out, -32768);
    check("sat_neg_clip", f_clip, 1);
    bus.ch_in = '0;
    run_frame();
    check("sat_zero_out", f_out, 0);
    check("sat_zero_clip", f_clip, 0);

    // Ramp ch0 gain down to 1, then -1*1 >>> 7 floors to -1.
    bus.ch_gain = {8'd128, 8'd128, 8'd128, 8'd1};
    for (int n = 0; n < 128; n++) run_frame();
    bus.ch_in = {16'sd0, 16'sd0, 16'sd0, -16'sd1};
    run_frame();
    check("floor_out", f_out, -1);
    check("floor_clip", f_clip, 0);
    check("latency_busy_to_valid", f_lat, 5);
    check("valid_width", f_width, 0);
    check("busy_at_valid", f_busy, 0);

    // Mute slew down and back up.
    bus.ch_in   = '0;
    bus.ch_gain = {8'd128, 8'd128, 8'd128, 8'd128};
    for (int n = 0; n < 128; n++) run_frame();
    bus.ch_in = {16'sd0, 16'sd0, 16'sd0, 16'sd12800};
    run_frame();
    check("unity_out", f_out, 12800);
    bus.mute = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      run_frame();
      g = (128 - (k - 1) < 0) ? 0 : 128 - (k - 1);
      check($sformatf("mute_down_%0d", k), f_out, 100 * g);
    end
    bus.mute = 1'b0;
    for (int j = 1; j <= 130; j++) begin
      run_frame();
      g = (j - 1 > 128) ? 128 : j - 1;
      check($sformatf("mute_up_%0d", j), f_out, 100 * g);
    end

    // Second edge 3 cycles after the first lands in MAC and is dropped.
    check("overrun_before", int'(bus.overrun), 0);
    valids = 0;
    @(negedge clock) bus.lrck = 1'b1;
    @(negedge clock) bus.lrck = 1'b0;
    @(negedge clock);
    @(negedge clock) bus.lrck = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clock);
      if (t == 0) bus.lrck = 1'b0;
      if (bus.mix_valid) valids++;
    end
    check("overrun_valids", valids, 1);
    check("overrun_set", int'(bus.overrun), 1);
    run_frame();
    check("overrun_sticky", int'(bus.overrun), 1);
    check("overrun_next_out", f_out, 12800);

    // Asynchronous reset in the middle of MAC.
    seen = 0;
    @(negedge clock) bus.lrck = 1'b1;
    for (int t = 0; t < 20 && seen == 0; t++) begin
      @(negedge clock);
      if (bus.busy) seen = 1;
    end
    check("rst_busy_seen", seen, 1);
    @(negedge clock);
    bus.lrck = 1'b0;
    reset    = 1'b1;
    #1;
    check_outputs_zero("rst_mid");
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    valids = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      if (bus.mix_valid) valids++;
    end
    check("rst_no_valid", valids, 0);
    run_frame();
    check("rst_first_out", f_out, 0);
    run_frame();
    check("rst_second_out", f_out, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
